// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// master = producer/consumer side, slave = the adder.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;
  logic [2:0]       nzp;

  modport master (
    output in_valid, A, B, cin, sub, out_ready,
    input  in_ready, out_valid, S, cout, ovf, nzp
  );

  modport slave (
    input  in_valid, A, B, cin, sub, out_ready,
    output in_ready, out_valid, S, cout, ovf, nzp
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready backpressure.
// Define CLA_NZP_EN to register LC-3 NZP condition codes with the result.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned GROUP            = 4,
  parameter int unsigned GROUPS_PER_STAGE = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  pipelined_cla_adder_if.slave  bus
);

  localparam int unsigned NG = WIDTH / GROUP;
  localparam int unsigned L  = NG / GROUPS_PER_STAGE;
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Slot 0 captures the accepted operands; slot s+1 holds the result of stage s.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             ovf;
  } stage_t;

  stage_t     stg_q [L+1];
  stage_t     stg_d [L+1];
  logic [L:0] vld_q;
  logic [L:0] vld_d;
  logic       en;
  logic       in_ready;

  assign en       = ~vld_q[L] | bus.out_ready;
  assign in_ready = en & ~Reset;

  always_comb begin : comb_next
    stage_t          cur;
    logic            c;
    logic            gg;
    logic            pp;
    logic            gb;
    logic            pb;
    logic [IW-1:0]   bi;
    stg_d = stg_q;
    vld_d = vld_q;
    cur   = '0;
    c     = 1'b0;
    gg    = 1'b0;
    pp    = 1'b0;
    gb    = 1'b0;
    pb    = 1'b0;
    bi    = '0;
    if (en) begin
      for (int unsigned s = 0; s <= L; s++) begin
        if (s == 0) begin
          vld_d[0] = bus.in_valid & in_ready;
          cur      = '0;
          cur.a    = bus.A;
          cur.bx   = bus.sub ? ~bus.B : bus.B;
          cur.c    = bus.sub | bus.cin;
        end else begin
          vld_d[s] = vld_q[s-1];
          cur      = stg_q[s-1];
          c        = cur.c;
          // Bit carries are lookahead prefixes off the group carry-in; the
          // group carry-out is G | P&cin, so groups chain on G/P only.
          for (int unsigned gi = 0; gi < GROUPS_PER_STAGE; gi++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int unsigned j = 0; j < GROUP; j++) begin
              bi          = IW'(((s - 1) * GROUPS_PER_STAGE + gi) * GROUP + j);
              gb          = cur.a[bi] & cur.bx[bi];
              pb          = cur.a[bi] ^ cur.bx[bi];
              cur.sum[bi] = pb ^ (gg | (pp & c));
              gg          = gb | (pb & gg);
              pp          = pp & pb;
            end
            c = gg | (pp & c);
          end
          cur.c = c;
          if (s == L) begin
            cur.ovf = (cur.a[WIDTH-1] == cur.bx[WIDTH-1]) &
                      (cur.sum[WIDTH-1] != cur.a[WIDTH-1]);
          end
        end
        // Bubbles advance the valid bit only, so S holds the last result.
        if (vld_d[s]) begin
          stg_d[s] = cur;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_q <= '0;
      for (int unsigned s = 0; s <= L; s++) begin
        stg_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      stg_q <= stg_d;
    end
  end

`ifdef CLA_NZP_EN
  logic [2:0] nzp_q;
  logic [2:0] nzp_d;

  always_comb begin
    nzp_d = nzp_q;
    if (en && vld_d[L]) begin
      nzp_d = {stg_d[L].sum[WIDTH-1],
               stg_d[L].sum == '0,
               ~stg_d[L].sum[WIDTH-1] & (|stg_d[L].sum)};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      nzp_q <= '0;
    end else begin
      nzp_q <= nzp_d;
    end
  end

  assign bus.nzp = nzp_q;
`else
  assign bus.nzp = '0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_q[L];
  assign bus.S         = stg_q[L].sum;
  assign bus.cout      = stg_q[L].c;
  assign bus.ovf       = stg_q[L].ovf;

endmodule
